// File: rtl/dsp_pkg.sv
// Shared constants and sample types for the audio DSP chain and the codec serial ports.
package dsp_pkg;

  localparam int WS          = 16;
  localparam int BCLK_HALF   = 6;
  localparam int FRAME_SLOTS = 2 * WS;

  typedef struct packed {
    logic [WS-1:0] left;
    logic [WS-1:0] right;
  } stereo_t;

endpackage

// File: rtl/dsp_bclk_gen.sv
// Bit-clock divider: toggles bclk_o every HALF clocks and flags the edge on which it will rise or fall.
module dsp_bclk_gen
  import dsp_pkg::*;
#(
  parameter int HALF = BCLK_HALF
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  // Strobes mark the cycle whose closing edge changes bclk, so users update in step with it.
  assign bclk_o = bclk_q;
  assign rise_o = wrap & ~bclk_q;
  assign fall_o = wrap & bclk_q;

endmodule

// File: rtl/dsp_i2s_dac_tx.sv
// I2S transmitter to the codec DAC: one-deep sample holding register, frame loader and serializer.
module dsp_i2s_dac_tx
  import dsp_pkg::*;
#(
  parameter int ws       = WS,
  parameter int bclkHalf = BCLK_HALF
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [ws-1:0] iLeft,
  input  logic [ws-1:0] iRight,
  input  logic          iValid,
  output logic          oReady,
  output logic          oBCLK,
  output logic          oLRCK,
  output logic          oDAT,
  output logic          oFrame,
  output logic          oUnderrun
);

  localparam int SLOTS = 2 * ws;
  localparam int SW    = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(SLOTS - 1);
  localparam logic [SW-1:0] RIGHT_SLOT = SW'(ws);

  logic bclk_fall, bclk_rise_unused;

  dsp_bclk_gen #(.HALF(bclkHalf)) u_bclk (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .bclk_o (oBCLK),
    .rise_o (bclk_rise_unused),
    .fall_o (bclk_fall)
  );

  logic [SW-1:0]    slot_q, slot_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             frame_q, frame_d;
  logic             under_q, under_d;
  logic             full_q, full_d;
  logic [SLOTS-1:0] hold_q, hold_d;
  logic [SLOTS-1:0] word_q, word_d;
  logic [SLOTS-1:0] shift_q, shift_d;
  logic             frame_load, accept;

  always_comb begin
    slot_d  = slot_q;
    lrck_d  = lrck_q;
    dat_d   = dat_q;
    frame_d = 1'b0;
    under_d = 1'b0;
    full_d  = full_q;
    hold_d  = hold_q;
    word_d  = word_q;
    shift_d = shift_q;

    frame_load = bclk_fall && (slot_q == LAST_SLOT);
    // A pair offered on the load edge with an empty holding register goes straight to the wire.
    accept     = iValid && !full_q && !frame_load;

    if (accept) begin
      hold_d = {iLeft, iRight};
      full_d = 1'b1;
    end

    if (bclk_fall) begin
      slot_d = frame_load ? '0 : slot_q + SW'(1);
      lrck_d = (slot_d >= RIGHT_SLOT);
      if (frame_load) begin
        frame_d = 1'b1;
        dat_d   = word_q[0];
        if (full_q) begin
          word_d = hold_q;
          full_d = 1'b0;
        end else if (iValid) begin
          word_d = {iLeft, iRight};
        end else begin
          under_d = 1'b1;
        end
        shift_d = word_d;
      end else begin
        dat_d   = shift_q[SLOTS-1];
        shift_d = {shift_q[SLOTS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      slot_q  <= LAST_SLOT;
      lrck_q  <= 1'b1;
      dat_q   <= 1'b0;
      frame_q <= 1'b0;
      under_q <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      word_q  <= '0;
      shift_q <= '0;
    end else begin
      slot_q  <= slot_d;
      lrck_q  <= lrck_d;
      dat_q   <= dat_d;
      frame_q <= frame_d;
      under_q <= under_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
      shift_q <= shift_d;
    end
  end

  assign oReady    = ~full_q;
  assign oLRCK     = lrck_q;
  assign oDAT      = dat_q;
  assign oFrame    = frame_q;
  assign oUnderrun = under_q;

endmodule

// File: tb/tb_dsp_i2s_dac_tx.sv
// Self-checking bench for dsp_i2s_dac_tx: cycle-count reference model plus literal frame checks.
module tb_dsp_i2s_dac_tx;

  localparam int WS_T  = 16;
  localparam int H     = 2;
  localparam int SLOTS = 2 * WS_T;
  localparam int FRAME = SLOTS * 2 * H;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [WS_T-1:0] iLeft = '0, iRight = '0;
  logic            iValid = 1'b0;
  logic            oReady, oBCLK, oLRCK, oDAT, oFrame, oUnderrun;

  dsp_i2s_dac_tx #(.ws(WS_T), .bclkHalf(H)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iLeft     (iLeft),
    .iRight    (iRight),
    .iValid    (iValid),
    .oReady    (oReady),
    .oBCLK     (oBCLK),
    .oLRCK     (oLRCK),
    .oDAT      (oDAT),
    .oFrame    (oFrame),
    .oUnderrun (oUnderrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derived from the number of clocks since reset release.
  int          k = 0;
  int          m_slot = SLOTS - 1;
  bit          m_full = 0;
  logic [31:0] m_hold = '0, m_word = '0;
  bit          e_bclk = 0, e_lrck = 1, e_dat = 0, e_frame = 0, e_under = 0;
  logic [31:0] cap = '0;
  bit          have_prev = 0;
  logic [31:0] rx[$];

  always @(posedge clk) begin
    bit          v, pre_full, fall, frame_edge;
    logic [31:0] din;
    v = iValid;
    din = {iLeft, iRight};
    if (rst) begin
      k = 0; m_slot = SLOTS - 1; m_full = 0; m_hold = '0; m_word = '0;
      e_bclk = 0; e_lrck = 1; e_dat = 0; e_frame = 0; e_under = 0;
      have_prev = 0;
    end else begin
      k++;
      pre_full = m_full;
      fall = (k % (2 * H)) == 0;
      e_bclk = ((k / H) % 2) == 1;
      e_frame = 0;
      e_under = 0;
      frame_edge = 0;
      if (fall) begin
        m_slot = (k / (2 * H) - 1) % SLOTS;
        e_lrck = m_slot >= WS_T;
        if (m_slot == 0) begin
          frame_edge = 1;
          e_frame = 1;
          e_dat = m_word[0];
          if (pre_full) begin
            m_word = m_hold;
            m_full = 0;
          end else if (v) m_word = din;
          else e_under = 1;
        end else begin
          e_dat = m_word[SLOTS - m_slot];
        end
      end
      if (v && !pre_full && !frame_edge) begin
        m_hold = din;
        m_full = 1;
      end
    end
    #1;
    chk("bclk", {31'd0, oBCLK}, {31'd0, e_bclk});
    chk("lrck", {31'd0, oLRCK}, {31'd0, e_lrck});
    chk("dat", {31'd0, oDAT}, {31'd0, e_dat});
    chk("frame", {31'd0, oFrame}, {31'd0, e_frame});
    chk("underrun", {31'd0, oUnderrun}, {31'd0, e_under});
    chk("ready", {31'd0, oReady}, {31'd0, !m_full});
    // Codec-side view: sample oDAT at each BCLK rise and rebuild the transmitted words.
    if (!rst && (k % (2 * H)) == H) begin
      if (m_slot == 0) begin
        if (have_prev) begin
          cap[0] = oDAT;
          rx.push_back(cap);
        end
        have_prev = 1;
      end else begin
        cap[SLOTS - m_slot] = oDAT;
      end
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n;
    bit acc;
    @(negedge clk);
    iValid = 1'b1; iLeft = l; iRight = r;
    n = 0;
    do begin
      @(posedge clk);
      acc = oReady;
      n++;
    end while (!acc && n < 2000);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: pair %h/%h not accepted within %0d cycles", l, r, n);
    end
    $display("send %h/%h accepted after %0d cycles", l, r, n);
  endtask

  task automatic idle();
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!oFrame && n < 4 * FRAME);
    if (!oFrame) begin
      checks++; errors++;
      $display("FAIL wait_frame: no oFrame within %0d cycles", n);
    end
  endtask

  task automatic expect_seq(input string name, input logic [31:0] w0, input logic [31:0] w1, input bit two);
    bit found = 0;
    for (int i = 0; i < rx.size(); i++)
      if (rx[i] == w0 && (!two || (i + 1 < rx.size() && rx[i+1] == w1))) found = 1;
    chk(name, {31'd0, found}, 32'd1);
    $display("frame sequence %s: %h %h found=%0d", name, w0, w1, found);
  endtask

  initial begin
    int n, unders;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_bclk", {31'd0, oBCLK}, 32'd0);
    chk("rst_lrck", {31'd0, oLRCK}, 32'd1);
    chk("rst_ready", {31'd0, oReady}, 32'd1);
    chk("rst_dat", {31'd0, oDAT}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("first_rise", {31'd0, oBCLK}, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("first_fall_bclk", {31'd0, oBCLK}, 32'd0);
    chk("first_frame", {31'd0, oFrame}, 32'd1);
    chk("first_lrck", {31'd0, oLRCK}, 32'd0);
    chk("first_underrun", {31'd0, oUnderrun}, 32'd1);

    // Serialize then underrun repeats
    send(16'hA5A5, 16'h0F0F);
    idle();
    wait_frame();
    unders = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (oUnderrun) unders++;
    end
    chk("underrun_count", unders, 32'd3);
    $display("underrun pulses over 3 frames: %0d", unders);

    // Back-pressure
    send(16'h8000, 16'h7FFF);
    send(16'h0001, 16'hFFFF);
    idle();
    repeat (3 * FRAME) @(posedge clk);

    // Bypass on the exact frame-load cycle
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(((k + 1) % (2 * H)) == 0 && (((k + 1) / (2 * H) - 1) % SLOTS) == 0 && !m_full)
               && n < 4 * FRAME);
    iValid = 1'b1; iLeft = 16'h1234; iRight = 16'h5678;
    @(posedge clk); #1;
    chk("bypass_frame", {31'd0, oFrame}, 32'd1);
    chk("bypass_underrun", {31'd0, oUnderrun}, 32'd0);
    chk("bypass_ready", {31'd0, oReady}, 32'd1);
    $display("bypass 1234/5678 offered on frame-load cycle");
    idle();
    repeat (2 * FRAME) @(posedge clk);

    // Randomized traffic with random gaps
    for (int t = 0; t < 8; t++) begin
      send(16'($urandom), 16'($urandom));
      idle();
      repeat ($urandom_range(0, 300)) @(posedge clk);
    end
    repeat (2 * FRAME) @(posedge clk);

    expect_seq("serialize_repeat", 32'hA5A50F0F, 32'hA5A50F0F, 1);
    expect_seq("backpressure", 32'h80007FFF, 32'h0001FFFF, 1);
    expect_seq("bypass", 32'h12345678, 32'h0, 0);

    // Reset in the middle of a frame
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (m_slot != 10 && n < 4 * FRAME);
    rst = 1'b1;
    #1;
    chk("midrst_bclk", {31'd0, oBCLK}, 32'd0);
    chk("midrst_lrck", {31'd0, oLRCK}, 32'd1);
    chk("midrst_dat", {31'd0, oDAT}, 32'd0);
    chk("midrst_ready", {31'd0, oReady}, 32'd1);
    chk("midrst_frame", {31'd0, oFrame}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("restart_frame", {31'd0, oFrame}, 32'd1);
    chk("restart_underrun", {31'd0, oUnderrun}, 32'd1);
    repeat (2 * FRAME + 8) @(posedge clk); #1;
    chk("restart_zero_word", rx[rx.size() - 1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
